// File: rtl/nco_pkg.sv
// Shared NCO phase generator definitions: default widths and the FTW loader state type.
package nco_pkg;

  localparam int ACC_W_DEF   = 24;
  localparam int PHASE_W_DEF = 8;
  localparam int FTW_BYTES   = ACC_W_DEF / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } ld_state_t;

  function automatic int ftw_bytes(input int acc_w);
    return acc_w / 8;
  endfunction

endpackage

// File: rtl/nco_phase_gen_ftw_loader.sv
// Byte-serial FTW loader: collects LSB-first bytes into a shadow word and holds
// it pending until the accumulator acknowledges the commit.
module ftw_loader
  import nco_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             commit_req,
  output logic [ACC_W-1:0] shadow,
  input  logic             commit_ack
);

  localparam int NB    = ftw_bytes(ACC_W);
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  ld_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             last;

  assign xfer = byte_valid && byte_ready;
  assign last = (cnt == CNT_W'(NB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      byte_ready <= 1'b1;
      commit_req <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (xfer) begin
            shadow[int'(cnt)*8 +: 8] <= byte_in;
            // Final byte closes the word; ready drops so nothing lands while pending.
            if (last) begin
              cnt        <= '0;
              state      <= COMMIT;
              byte_ready <= 1'b0;
              commit_req <= 1'b1;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= COLLECT;
            end
          end
        end
        COMMIT: begin
          if (commit_ack) begin
            state      <= IDLE;
            byte_ready <= 1'b1;
            commit_req <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          byte_ready <= 1'b1;
          commit_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/nco_phase_gen.sv
// NCO phase accumulator; a newly loaded FTW is swapped in on a carry edge so
// frequency changes land on cycle boundaries.
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clear,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap,
  output logic               ftw_loaded
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw;
  logic [ACC_W-1:0] shadow;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             commit_req;
  logic             commit;

  ftw_loader #(.ACC_W(ACC_W)) u_loader (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .commit_req (commit_req),
    .shadow     (shadow),
    .commit_ack (commit)
  );

  assign sum   = {1'b0, acc} + {1'b0, ftw};
  assign carry = sum[ACC_W];

  // Idle or clearing accumulator has no cycle boundary to respect, so commit at once.
  assign commit = commit_req && (phase_clear || !en || carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      ftw        <= '0;
      wrap       <= 1'b0;
      ftw_loaded <= 1'b0;
    end else begin
      if (phase_clear) begin
        acc  <= '0;
        wrap <= 1'b0;
      end else if (en) begin
        acc  <= sum[ACC_W-1:0];
        wrap <= carry;
      end else begin
        wrap <= 1'b0;
      end
      // The add on a carry-commit edge still uses the old word.
      if (commit) ftw <= shadow;
      ftw_loaded <= commit;
    end
  end

  assign phase = acc[ACC_W-1 -: PHASE_W];

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_nco_phase_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       phase_clear = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic [7:0] phase;
  logic       wrap;
  logic       ftw_loaded;

  nco_phase_gen #(.ACC_W(24), .PHASE_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .phase_clear (phase_clear),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .phase       (phase),
    .wrap        (wrap),
    .ftw_loaded  (ftw_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] ph;
    logic       wr;
    logic       ld;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ld_cnt = 0;
  int   wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (ftw_loaded) ld_cnt = ld_cnt + 1;
    if (wrap) wr_cnt = wr_cnt + 1;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks = checks + 1;
      if (phase !== e.ph || wrap !== e.wr || ftw_loaded !== e.ld || byte_ready !== e.rdy) begin
        errors = errors + 1;
        $display("FAIL %s cyc=%0d: got phase=%02h wrap=%0b ld=%0b rdy=%0b, want phase=%02h wrap=%0b ld=%0b rdy=%0b",
                 e.name, cyc, phase, wrap, ftw_loaded, byte_ready, e.ph, e.wr, e.ld, e.rdy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic [7:0] ph, input logic wr,
                            input logic ld, input logic rdy);
    exp_t e;
    e.cyc = cyc; e.name = name; e.ph = ph; e.wr = wr; e.ld = ld; e.rdy = rdy;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    int   n;
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    do begin
      r = byte_ready;
      tick();
      n++;
    end while (!r && n < 600);
    if (!r) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL send_byte timeout: byte %02h not accepted after %0d cycles", b, n);
    end
    byte_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and zero-FTW hold
    tick();
    expect_now("reset", 8'h00, 0, 0, 1);
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) tick();
    expect_now("ftw0_hold", 8'h00, 0, 0, 1);

    // Basic rate: FTW 0x010000 loaded while idle
    en = 1'b0;
    send3(8'h00, 8'h00, 8'h01);
    expect_now("basic_pending", 8'h00, 0, 0, 0);
    tick();
    expect_now("basic_loaded", 8'h00, 0, 1, 1);
    en = 1'b1;
    tick();
    expect_now("step1", 8'h01, 0, 0, 1);
    for (int i = 2; i <= 256; i++) begin
      tick();
      expect_now("step", 8'(i), (i == 256), 0, 1);
    end
    for (int i = 1; i <= 8'h80; i++) begin
      tick();
      expect_now("step2", 8'(i), 0, 0, 1);
    end

    // Wrap-aligned commit of 0x040000 while running at phase 0x80
    send3(8'h00, 8'h00, 8'h04);
    expect_now("wa_pending", 8'h83, 0, 0, 0);
    byte_in    = 8'h80;
    byte_valid = 1'b1;
    for (int j = 1; j <= 8'h7C; j++) begin
      tick();
      expect_now("wa_backpressure", 8'(8'h83 + j), 0, 0, 0);
    end
    tick();
    expect_now("wa_commit", 8'h00, 1, 1, 1);
    tick();
    expect_now("bp_accept", 8'h04, 0, 0, 1);
    byte_valid = 1'b0;
    en = 1'b0;
    tick();
    expect_now("hold", 8'h04, 0, 0, 1);
    send_byte(8'hFF);
    send_byte(8'h7F);
    expect_now("cnt1_pending", 8'h04, 0, 0, 0);
    tick();
    expect_now("cnt1_loaded", 8'h04, 0, 1, 1);

    // Reach acc=0xFFFF00 with FTW 0x7FFF80, then clear with a pending load
    phase_clear = 1'b1;
    tick();
    expect_now("clear", 8'h00, 0, 0, 1);
    phase_clear = 1'b0;
    en = 1'b1;
    tick();
    expect_now("run_7f", 8'h7F, 0, 0, 1);
    tick();
    expect_now("run_ff", 8'hFF, 0, 0, 1);
    en = 1'b0;
    send3(8'h00, 8'h02, 8'h00);
    expect_now("ftw200_pending", 8'hFF, 0, 0, 0);
    tick();
    expect_now("ftw200_loaded", 8'hFF, 0, 1, 1);
    send3(8'h00, 8'h00, 8'h08);
    expect_now("clr_pending", 8'hFF, 0, 0, 0);
    en = 1'b1;
    phase_clear = 1'b1;
    tick();
    expect_now("clear_prio", 8'h00, 0, 1, 1);
    phase_clear = 1'b0;
    tick();
    expect_now("new_ftw_after_clear", 8'h08, 0, 0, 1);
    en = 1'b0;

    // Mid-load asynchronous reset, then a fresh load of 0x008000
    send_byte(8'h55);
    send_byte(8'hAA);
    #2;
    rst = 1'b1;
    expect_now("midload_reset", 8'h00, 0, 0, 1);
    tick();
    rst = 1'b0;
    send3(8'h00, 8'h80, 8'h00);
    expect_now("fresh_pending", 8'h00, 0, 0, 0);
    tick();
    expect_now("fresh_loaded", 8'h00, 0, 1, 1);
    en = 1'b1;
    repeat (2) tick();
    expect_now("fresh_rate1", 8'h01, 0, 0, 1);
    repeat (2) tick();
    expect_now("fresh_rate2", 8'h02, 0, 0, 1);
    en = 1'b0;

    repeat (2) tick();
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    checks = checks + 1;
    if (ld_cnt != 6) begin
      errors = errors + 1;
      $display("FAIL ftw_loaded_count: got %0d, required 6", ld_cnt);
    end
    checks = checks + 1;
    if (wr_cnt != 2) begin
      errors = errors + 1;
      $display("FAIL wrap_count: got %0d, required 2", wr_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
